// File: rtl/bfly_ingress_sched_pkg.sv
// Shared types and defaults for the butterfly ingress scheduler.
// Optional statistics build: define BFLY_SCHED_STATS_EN.
package bfly_pkg;

    localparam int unsigned DEF_DW      = 35;
    localparam int unsigned DEF_N       = 8;
    localparam int unsigned DEF_CREDITS = 4;
    localparam int unsigned IDX_W       = $clog2(DEF_N);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    // Destination index carried in the top bits of a beat (default geometry).
    function automatic logic [IDX_W-1:0] dst_of(input logic [DEF_DW-1:0] data);
        return data[DEF_DW-1 -: IDX_W];
    endfunction

endpackage

// File: rtl/bfly_ingress_sched_if.sv
// Upstream stream, butterfly input ports and credit-return pulses.
// The scheduler uses the slave modport; the upstream/network side uses master.
interface bfly_ingress_sched_if
    import bfly_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned N  = DEF_N
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DW-1:0]         s_data;
    logic [N-1:0]          m_valid;
    logic [N-1:0]          m_ready;
    logic [N-1:0][DW-1:0]  m_data;
    logic [N-1:0]          ret_valid;

    modport slave (
        input  s_valid, s_data, m_ready, ret_valid,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready, ret_valid,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/bfly_ingress_sched_credit_ctr.sv
// Per-destination credit counter: take on dispatch, give on return.
// err flags a lone return while the counter is already full.
module bfly_credit_ctr #(
    parameter int unsigned CREDITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic take,
    input  logic give,
    output logic avail,
    output logic full,
    output logic err
);
    localparam int unsigned CW = $clog2(CREDITS + 1);

    logic [CW-1:0] cnt;

    assign avail = (cnt != '0);
    assign full  = (cnt == CW'(CREDITS));
    assign err   = give && !take && full;

    // Count in-flight credit; simultaneous take/give cancel, overflow is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CW'(CREDITS);
        end else if (take && !give) begin
            cnt <= cnt - CW'(1);
        end else if (give && !take && !full) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bfly_ingress_sched.sv
// Credit-based ingress scheduler feeding the butterfly input ports in
// rotating order. Optional statistics outputs: define BFLY_SCHED_STATS_EN.
module bfly_ingress_sched
    import bfly_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned N       = DEF_N,
    parameter int unsigned CREDITS = DEF_CREDITS
) (
    input  logic                clk,
    input  logic                rst_n,
    bfly_ingress_sched_if.slave bus,
    input  logic                drain_req,
    output logic                drain_done,
    output logic                idle,
    output logic                cred_err
`ifdef BFLY_SCHED_STATS_EN
    ,
    output logic [N-1:0][31:0]  stat_disp,
    output logic [31:0]         stat_stall
`endif
);
    localparam int unsigned PTR_W = $clog2(N);

    sched_state_e     state;
    logic             started;
    logic             hold_v;
    logic [PTR_W-1:0] hold_port;
    logic [DW-1:0]    hold_data;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] dst;
    logic [N-1:0]     take;
    logic [N-1:0]     avail;
    logic [N-1:0]     full;
    logic [N-1:0]     err;
    logic             hold_free;
    logic             accept;

    assign dst       = bus.s_data[DW-1 -: PTR_W];
    assign hold_free = !hold_v || bus.m_ready[hold_port];
    // drain_req is folded in so a drain request wins over an accept in the same cycle
    assign bus.s_ready = started && (state == RUN) && !drain_req && avail[dst] && hold_free;
    assign accept      = bus.s_valid && bus.s_ready;
    assign idle        = (&full) && !hold_v;

    // Decode the accepted beat's destination into per-counter take strobes.
    always_comb begin
        take = '0;
        if (accept) begin
            take[dst] = 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cred
        bfly_credit_ctr #(.CREDITS(CREDITS)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .take  (take[i]),
            .give  (bus.ret_valid[i]),
            .avail (avail[i]),
            .full  (full[i]),
            .err   (err[i])
        );
    end

    // Holding register and rotating port pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v    <= 1'b0;
            hold_port <= '0;
            hold_data <= '0;
            ptr       <= '0;
        end else if (accept) begin
            hold_v    <= 1'b1;
            hold_port <= ptr;
            hold_data <= bus.s_data;
            ptr       <= ptr + PTR_W'(1);
        end else if (hold_v && bus.m_ready[hold_port]) begin
            hold_v <= 1'b0;
        end
    end

    // Present the held beat on its port only; every other port idles at zero.
    always_comb begin
        bus.m_valid = '0;
        bus.m_data  = '0;
        if (hold_v) begin
            bus.m_valid[hold_port] = 1'b1;
            bus.m_data[hold_port]  = hold_data;
        end
    end

    // Run/drain/done sequencing; started keeps s_ready low until the first clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            drain_done <= 1'b0;
            started    <= 1'b0;
        end else begin
            started    <= 1'b1;
            drain_done <= 1'b0;
            unique case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (idle) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!drain_req) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Sticky credit overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred_err <= 1'b0;
        end else if (|err) begin
            cred_err <= 1'b1;
        end
    end

`ifdef BFLY_SCHED_STATS_EN
    // Free-running dispatch and stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_disp  <= '0;
            stat_stall <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (take[i]) stat_disp[i] <= stat_disp[i] + 32'd1;
            end
            if ((state == RUN) && bus.s_valid && !bus.s_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/bfly_ingress_sched.md
# bfly_ingress_sched

Credit-based ingress scheduler for the `butterfly` network. It accepts one upstream valid/ready stream whose beats carry a destination index in their top bits. Each beat is dispatched onto one of the N butterfly input ports in rotating order. In-flight beats per destination are bounded by a credit counter, and a credit is returned when that butterfly output port completes a handshake. A drain sequence stops injection and signals when the network is empty.

## Interface
- `DW`, 35: beat width; destination field is `DW-1 -: $clog2(N)`.
- `N`, 8: butterfly port count, power of two, ≥2.
- `CREDITS`, 4: maximum in-flight beats per destination, 1..15.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `s_valid`  in  1: upstream beat valid.
- `s_ready`  out  1: upstream beat accepted.
- `s_data`  in  DW: upstream beat.
- `m_valid[N]`  out  1 each: butterfly input valid.
- `m_ready[N]`  in  1 each: butterfly input ready.
- `m_data[N]`  out  DW each: butterfly input data.
- `ret_valid[N]`  in  1 each: pulse per butterfly output handshake (`o_valid[d] & o_ready[d]`).
- `drain_req`  in  1: level; request drain.
- `drain_done`  out  1: one-cycle pulse when drain completes.
- `idle`  out  1: all credits home and no beat held.
- `cred_err`  out  1: sticky; a credit was returned to a full counter.

## Operation
- One holding register (`hold_v`, `hold_port`, `hold_data`) drives exactly one `m_valid[hold_port]`. All other `m_valid` and `m_data` are 0.
- Port pointer `ptr` (`$clog2(N)` bits) names the port the next accepted beat goes to. It advances +1 mod N on every accept and wraps N-1→0.
- Credit counter `cred[d]` is `$clog2(CREDITS+1)` bits and resets to CREDITS.
  - Accept to destination d: decrement.
  - `ret_valid[d]`: increment.
  - Both in the same cycle: unchanged.
  - Return while `cred[d]==CREDITS`: counter holds and `cred_err` sets. Only reset clears it.
- `s_ready = (state==RUN) & (cred[dst(s_data)]!=0) & (!hold_v | m_ready[hold_port])`. It depends combinationally on `s_data`. Upstream must hold `s_data` stable while `s_valid` is high.
- On accept, the holding register loads `{ptr, s_data}`. Back-to-back accepts at 1 beat/cycle are allowed while the held port is ready.
- On `m_ready[hold_port] & hold_v` with no accept, `hold_v` clears.
- State machine:
  - RUN→DRAIN when `drain_req` is 1. This takes priority over an accept in that cycle, so `s_ready` is 0 in DRAIN.
  - DRAIN→DONE when `idle`. `drain_done` pulses on this transition.
  - DONE→RUN when `drain_req` is 0.
  - DONE holds `s_ready` at 0.
- Credits keep returning in every state.

## Timing
- Reset values:
  - `s_ready` 0 (asserted from the first clock after reset release, once in RUN).
  - `m_valid` all 0; `m_data` all 0.
  - `drain_done` 0, `idle` 1, `cred_err` 0.
  - `ptr` 0, state RUN.
- Latency: accept at edge k → `m_valid[port]` high from edge k until its handshake.
- Credit return at edge k is visible to `s_ready` in cycle k+1.
- `drain_req` asserted with network empty: DRAIN is entered at the next edge and `drain_done` pulses one cycle later.
- Reset mid-operation: all state returns to reset values immediately. Beats in flight are abandoned, and the network must be reset together with this block.

## Configuration
- `BFLY_SCHED_STATS_EN` defined adds these outputs:
  - `stat_disp[N]`: 32 bits each, per-destination accept count.
  - `stat_stall`: 32 bits, counts cycles with `s_valid & !s_ready` in RUN.
  - All counters wrap at 2^32, clear on reset, and are never cleared otherwise.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

## Structure
- Package `bfly_pkg`:
  - `IDX_W = $clog2(N)`.
  - State enum `sched_state_e` {RUN, DRAIN, DONE}.
  - Destination-extract function `dst_of(data)`.
- One sub-module `bfly_credit_ctr`, instanced N times: a single counter with `take`, `give`, `avail` and `err` signals.
- The holding register, pointer and FSM live in the top module.

## Test plan
- All-to-all sweep: 64 beats (src 0..7 × dst 0..7), `m_ready` tied 1, `ret_valid` echoed 3 cycles later → every beat reaches the correct dst, ports used in order 0..7 repeatedly, `idle` returns to 1.
- Credit stall: 5 beats to dst 3, no returns → 4 accepted, then `s_ready` is 0; one `ret_valid[3]` → 5th accepted in the next cycle.
- Backpressure: `m_ready[2]` held 0 for 10 cycles with beat held on port 2 → `m_valid[2]` and `m_data[2]` stable, `s_ready` 0, no beat lost.
- Simultaneous take/give on dst 5 at `cred==1` → counter stays 1 and the next beat is accepted.
- Drain: `drain_req` raised with 3 beats in flight → `s_ready` 0 immediately, `drain_done` pulses one cycle after the third return, RUN resumes after `drain_req` drops.
- Spurious `ret_valid[0]` at full credit → `cred_err` 1 and stays set until `rst_n` pulse.
